mem_stage_lsu: RTL

- Memory stage directly downstream of the execute-stage ALU.
- Consumes the ALU result, used as the effective address or as pass-through data, plus the store operand.
- Performs byte/half/word/dword load-store through a req/ack data-memory port and hands an aligned, extended result to write-back over a valid/ready handshake.
- Non-memory ops pass through with one cycle of latency.

---
 rtl/mem_stage_lsu_pkg.sv | 43 ++++
 rtl/mem_stage_lsu_align.sv | 56 +++++
 rtl/mem_stage_lsu.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/mem_stage_lsu_pkg.sv
// mem_stage_lsu_pkg
// Shared encodings for the memory-stage load/store unit:
//   - access size encodings (B/H/W/D)
//   - FSM state type (IDLE / REQ / RESP)
//   - data-memory byte-mask width and helpers for the base mask and
//     natural-alignment test (the latter is used only when
//     MISALIGN_TRAP_EN is defined).
package mem_stage_lsu_pkg;

  localparam logic [1:0] LS_SIZE_B = 2'd0;
  localparam logic [1:0] LS_SIZE_H = 2'd1;
  localparam logic [1:0] LS_SIZE_W = 2'd2;
  localparam logic [1:0] LS_SIZE_D = 2'd3;

  localparam int DMEM_MASK_W = 8;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'd0,
    LSU_REQ  = 2'd1,
    LSU_RESP = 2'd2
  } lsu_state_t;

  // Byte-enable pattern of an access that starts at lane 0.
  function automatic logic [DMEM_MASK_W-1:0] size_base_mask(input logic [1:0] size);
    case (size)
      LS_SIZE_B: size_base_mask = 8'h01;
      LS_SIZE_H: size_base_mask = 8'h03;
      LS_SIZE_W: size_base_mask = 8'h0F;
      default:   size_base_mask = 8'hFF;
    endcase
  endfunction

  // True when the access is not naturally aligned for its size.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [2:0] off);
    case (size)
      LS_SIZE_B: is_misaligned = 1'b0;
      LS_SIZE_H: is_misaligned = off[0];
      LS_SIZE_W: is_misaligned = |off[1:0];
      default:   is_misaligned = |off;
    endcase
  endfunction

endpackage

// File: rtl/mem_stage_lsu_align.sv
// mem_stage_lsu_align
// Purely combinational lane steering for the LSU.
//   off         in  byte offset of the access inside the 8-byte line
//   size        in  access size (LS_SIZE_*)
//   ls_unsigned in  zero-extend load data (ignored for D)
//   store_data  in  LSB-aligned store operand
//   rdata       in  8-byte line read data
//   wmask       out byte enables, truncated to the line
//   wdata       out store data shifted into its lanes
//   load_data   out extracted and extended load result
// Bytes that fall beyond the line are dropped: the mask and write data
// lose them through truncation, and the load shift fills with zeros.
module mem_stage_lsu_align
  import mem_stage_lsu_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [2:0]             off,
  input  logic [1:0]             size,
  input  logic                   ls_unsigned,
  input  logic [XLEN-1:0]        store_data,
  input  logic [XLEN-1:0]        rdata,
  output logic [DMEM_MASK_W-1:0] wmask,
  output logic [XLEN-1:0]        wdata,
  output logic [XLEN-1:0]        load_data
);

  logic [5:0]      shamt;
  logic [XLEN-1:0] shifted;
  logic            ext;

  assign shamt = {off, 3'b000};

  always_comb begin
    wmask   = size_base_mask(size) << off;
    wdata   = store_data << shamt;
    shifted = rdata >> shamt;
    ext     = 1'b0;
    case (size)
      LS_SIZE_B: begin
        ext       = ~ls_unsigned & shifted[7];
        load_data = {{(XLEN-8){ext}}, shifted[7:0]};
      end
      LS_SIZE_H: begin
        ext       = ~ls_unsigned & shifted[15];
        load_data = {{(XLEN-16){ext}}, shifted[15:0]};
      end
      LS_SIZE_W: begin
        ext       = ~ls_unsigned & shifted[31];
        load_data = {{(XLEN-32){ext}}, shifted[31:0]};
      end
      default: load_data = shifted;
    endcase
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu
// Memory stage behind the EX-stage ALU. Accepts one op at a time from EX,
// performs a byte/half/word/dword access over a req/ack data-memory port
// (or passes the ALU result straight through for non-memory ops) and
// presents the result to write-back over valid/ready.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   ex_*              op from EX (valid/ready, load/store, size, signedness,
//                     alu_result, store_data, rd_addr)
//   dmem_*            data-memory request port (line-aligned address,
//                     lane-shifted wdata, byte mask, ack, line rdata)
//   wb_*              result to write-back (valid/ready, data, rd, wen)
// Optional feature macro: MISALIGN_TRAP_EN adds wb_exc_misalign and turns
// misaligned accesses into an immediate exception result instead of a
// truncated memory access.
module mem_stage_lsu
  import mem_stage_lsu_pkg::*;
#(
  parameter int XLEN = 64,
  parameter int RD_W = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ex_valid,
  output logic                   ex_ready,
  input  logic                   is_load,
  input  logic                   is_store,
  input  logic [1:0]             ls_size,
  input  logic                   ls_unsigned,
  input  logic [XLEN-1:0]        alu_result,
  input  logic [XLEN-1:0]        store_data,
  input  logic [RD_W-1:0]        rd_addr,
  output logic                   dmem_req,
  output logic                   dmem_we,
  output logic [XLEN-1:0]        dmem_addr,
  output logic [XLEN-1:0]        dmem_wdata,
  output logic [DMEM_MASK_W-1:0] dmem_wmask,
  input  logic                   dmem_ack,
  input  logic [XLEN-1:0]        dmem_rdata,
  output logic                   wb_valid,
  input  logic                   wb_ready,
  output logic [XLEN-1:0]        wb_data,
  output logic [RD_W-1:0]        wb_rd_addr,
`ifdef MISALIGN_TRAP_EN
  output logic                   wb_exc_misalign,
`endif
  output logic                   wb_wen
);

  lsu_state_t      state;
  logic [2:0]      off_q;
  logic [1:0]      size_q;
  logic            uns_q;
  logic            load_q;
  logic [RD_W-1:0] rd_q;

  logic [2:0]             align_off;
  logic [1:0]             align_size;
  logic [DMEM_MASK_W-1:0] align_wmask;
  logic [XLEN-1:0]        align_wdata;
  logic [XLEN-1:0]        align_load;

  // The single aligner serves the store path from the live EX inputs while
  // IDLE and the load path from the latched op while waiting for ack.
  assign align_off  = (state == LSU_IDLE) ? alu_result[2:0] : off_q;
  assign align_size = (state == LSU_IDLE) ? ls_size : size_q;

  mem_stage_lsu_align #(.XLEN(XLEN)) u_align (
    .off         (align_off),
    .size        (align_size),
    .ls_unsigned (uns_q),
    .store_data  (store_data),
    .rdata       (dmem_rdata),
    .wmask       (align_wmask),
    .wdata       (align_wdata),
    .load_data   (align_load)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= LSU_IDLE;
      off_q      <= '0;
      size_q     <= '0;
      uns_q      <= 1'b0;
      load_q     <= 1'b0;
      rd_q       <= '0;
      ex_ready   <= 1'b1;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
      dmem_wmask <= '0;
      wb_valid   <= 1'b0;
      wb_data    <= '0;
      wb_rd_addr <= '0;
      wb_wen     <= 1'b0;
`ifdef MISALIGN_TRAP_EN
      wb_exc_misalign <= 1'b0;
`endif
    end else begin
      case (state)
        LSU_IDLE: begin
          if (ex_valid) begin
            off_q      <= alu_result[2:0];
            size_q     <= ls_size;
            uns_q      <= ls_unsigned;
            load_q     <= is_load;
            rd_q       <= rd_addr;
            ex_ready   <= 1'b0;
            wb_rd_addr <= rd_addr;
`ifdef MISALIGN_TRAP_EN
            wb_exc_misalign <= 1'b0;
            if ((is_load | is_store) && is_misaligned(ls_size, alu_result[2:0])) begin
              // Report the faulting address instead of touching memory.
              state           <= LSU_RESP;
              wb_valid        <= 1'b1;
              wb_data         <= alu_result;
              wb_wen          <= 1'b0;
              wb_exc_misalign <= 1'b1;
            end else
`endif
            if (is_load | is_store) begin
              // is_load wins if both are set, so the access is a read.
              state      <= LSU_REQ;
              dmem_req   <= 1'b1;
              dmem_we    <= ~is_load;
              dmem_addr  <= {alu_result[XLEN-1:3], 3'b000};
              dmem_wdata <= align_wdata;
              dmem_wmask <= align_wmask;
            end else begin
              state    <= LSU_RESP;
              wb_valid <= 1'b1;
              wb_data  <= alu_result;
              wb_wen   <= (rd_addr != '0);
            end
          end
        end

        LSU_REQ: begin
          if (dmem_ack) begin
            state    <= LSU_RESP;
            dmem_req <= 1'b0;
            dmem_we  <= 1'b0;
            wb_valid <= 1'b1;
            if (load_q) begin
              wb_data    <= align_load;
              wb_rd_addr <= rd_q;
              wb_wen     <= (rd_q != '0);
            end else begin
              wb_data    <= '0;
              wb_rd_addr <= '0;
              wb_wen     <= 1'b0;
            end
          end
        end

        LSU_RESP: begin
          // ex_ready rises here, so the next op is taken one cycle later.
          if (wb_ready) begin
            state    <= LSU_IDLE;
            wb_valid <= 1'b0;
            wb_wen   <= 1'b0;
            ex_ready <= 1'b1;
          end
        end

        default: state <= LSU_IDLE;
      endcase
    end
  end

endmodule
